// File: rtl/led_sequencer.sv
// LED sequencer: debounced buttons step through COUNT/SCAN/BLINK/MIRROR patterns on 8 LEDs.
// Define LED_SEQ_PWM_EN to add btn[4] brightness control through a 4-bit PWM.
module led_sequencer #(
    parameter int unsigned TICK_BITS = 20,
    parameter int unsigned DB_TICKS  = 2
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [6:0] i_btn,
    output logic [7:0] o_led,
    output logic [1:0] o_mode
);

`ifdef LED_SEQ_PWM_EN
    localparam int unsigned NDB = 4;
`else
    localparam int unsigned NDB = 3;
`endif
    localparam int unsigned DBW = (DB_TICKS < 2) ? 1 : $clog2(DB_TICKS + 1);

    typedef enum logic [1:0] {
        M_COUNT  = 2'd0,
        M_SCAN   = 2'd1,
        M_BLINK  = 2'd2,
        M_MIRROR = 2'd3
    } mode_e;

    logic [TICK_BITS-1:0]      presc_q, presc_d;
    logic [6:0]                sync1_q, sync2_q;
    logic [NDB-1:0]            acc_q, acc_d, acc_prev_q;
    logic [NDB-1:0][DBW-1:0]   db_cnt_q, db_cnt_d;
    mode_e                     mode_q, mode_d;
    logic [7:0]                step_q, step_d;
    logic [2:0]                pos_q, pos_d;
    logic                      dir_down_q, dir_down_d;
    logic                      paused_q, paused_d;
    logic [7:0]                led_q, led_d;
    logic [1:0]                mode_out_q;

    logic                      tick_c;
    logic [NDB-1:0]            press_c;
    logic                      mode_chg_c;
    logic [1:0]                mode_inc_c, mode_dec_c;
    logic [7:0]                pat_c;

`ifdef LED_SEQ_PWM_EN
    logic [3:0]                pwm_cnt_q, pwm_cnt_d;
    logic [4:0]                duty_q, duty_d;
`endif

    // Tick, debounce, mode FSM, step/scan datapath and pattern select
    always_comb begin
        presc_d    = presc_q + TICK_BITS'(1);
        tick_c     = &presc_q;
        acc_d      = acc_q;
        db_cnt_d   = db_cnt_q;
        press_c    = acc_q & ~acc_prev_q;
        mode_d     = mode_q;
        mode_inc_c = mode_q + 2'd1;
        mode_dec_c = mode_q - 2'd1;
        step_d     = step_q;
        pos_d      = pos_q;
        dir_down_d = dir_down_q;
        paused_d   = paused_q ^ press_c[2];
        pat_c      = 8'h00;
        led_d      = 8'h00;

        // Index i debounces button bit i+1
        for (int unsigned i = 0; i < NDB; i++) begin
            if (sync2_q[i+1] == acc_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (tick_c) begin
                if (db_cnt_q[i] == DBW'(DB_TICKS - 1)) begin
                    acc_d[i]    = sync2_q[i+1];
                    db_cnt_d[i] = '0;
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DBW'(1);
                end
            end
        end

        case ({press_c[1], press_c[0]})
            2'b01:   mode_d = mode_e'(mode_inc_c);
            2'b10:   mode_d = mode_e'(mode_dec_c);
            default: mode_d = mode_q;
        endcase
        mode_chg_c = (mode_d != mode_q);

        if (mode_chg_c) begin
            step_d     = 8'd0;
            pos_d      = 3'd0;
            dir_down_d = 1'b0;
        end else if (tick_c && !paused_q) begin
            step_d = step_q + 8'd1;
            if (!dir_down_q) begin
                pos_d = pos_q + 3'd1;
                if (pos_q == 3'd6) dir_down_d = 1'b1;
            end else begin
                pos_d = pos_q - 3'd1;
                if (pos_q == 3'd1) dir_down_d = 1'b0;
            end
        end

        case (mode_q)
            M_COUNT:  pat_c = step_q;
            M_SCAN:   pat_c = 8'd1 << pos_q;
            M_BLINK:  pat_c = step_q[2] ? 8'hFF : 8'h00;
            M_MIRROR: pat_c = {1'b0, sync2_q};
            default:  pat_c = 8'h00;
        endcase

`ifdef LED_SEQ_PWM_EN
        pwm_cnt_d = pwm_cnt_q + 4'd1;
        duty_d    = duty_q;
        if (press_c[3]) begin
            case (duty_q)
                5'd16:   duty_d = 5'd8;
                5'd8:    duty_d = 5'd4;
                5'd4:    duty_d = 5'd1;
                default: duty_d = 5'd16;
            endcase
        end
        led_d = pat_c & {8{({1'b0, pwm_cnt_q} < duty_q)}};
`else
        led_d = pat_c;
`endif
    end

    // State and output registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            presc_q    <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            acc_q      <= '0;
            acc_prev_q <= '0;
            db_cnt_q   <= '0;
            mode_q     <= M_COUNT;
            step_q     <= 8'd0;
            pos_q      <= 3'd0;
            dir_down_q <= 1'b0;
            paused_q   <= 1'b0;
            led_q      <= 8'h00;
            mode_out_q <= 2'd0;
`ifdef LED_SEQ_PWM_EN
            pwm_cnt_q  <= 4'd0;
            duty_q     <= 5'd16;
`endif
        end else begin
            presc_q    <= presc_d;
            sync1_q    <= i_btn;
            sync2_q    <= sync1_q;
            acc_q      <= acc_d;
            acc_prev_q <= acc_q;
            db_cnt_q   <= db_cnt_d;
            mode_q     <= mode_d;
            step_q     <= step_d;
            pos_q      <= pos_d;
            dir_down_q <= dir_down_d;
            paused_q   <= paused_d;
            led_q      <= led_d;
            mode_out_q <= mode_q;
`ifdef LED_SEQ_PWM_EN
            pwm_cnt_q  <= pwm_cnt_d;
            duty_q     <= duty_d;
`endif
        end
    end

    assign o_led  = led_q;
    assign o_mode = mode_out_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer at TICK_BITS=4, DB_TICKS=2; times are in clock edges since reset release.
module tb_led_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  btn = 7'd0;
    logic [7:0]  led;
    logic [1:0]  mode;
    int unsigned ecnt;
    int          n_chk = 0;
    int          n_bad = 0;

    led_sequencer #(.TICK_BITS(4), .DB_TICKS(2)) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .i_btn  (btn),
        .o_led  (led),
        .o_mode (mode)
    );

    always #5 clk = ~clk;

    // Edge count since reset release; prescaler value equals ecnt mod 16
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ecnt <= 0;
        else        ecnt <= ecnt + 1;
    end

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_ecnt(input int unsigned t);
        while (ecnt < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] scan_exp [8];
        int         on_cnt;
        scan_exp = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40};

        // Reset held with buttons toggling
        repeat (4) begin
            @(negedge clk);
            btn = btn ^ 7'h5A;
        end
        #1;
        chk("rst_led", led, 8'h00);
        chk("rst_mode", {6'd0, mode}, 8'h00);
        btn = 7'd0;
        @(negedge clk);
        rst_n = 1'b1;

        // COUNT after release
        wait_ecnt(16);  chk("cnt_pre_tick", led, 8'h00);
        wait_ecnt(17);  chk("cnt_1", led, 8'h01);
        wait_ecnt(33);  chk("cnt_2", led, 8'h02);
        wait_ecnt(49);  chk("cnt_3", led, 8'h03);

        // Pause accepted on the tick that shows 5
        btn[3] = 1'b1;
        wait_ecnt(81);  chk("pause_at_5", led, 8'h05);
        btn[3] = 1'b0;
        wait_ecnt(161); chk("pause_5t", led, 8'h05);
        wait_ecnt(401); chk("pause_20t", led, 8'h05);
        btn[3] = 1'b1;
        wait_ecnt(447); chk("unpause_hold", led, 8'h05);
        wait_ecnt(449); chk("unpause_6", led, 8'h06);
        btn[3] = 1'b0;

        // One-tick glitch on next is rejected
        wait_ecnt(482); btn[1] = 1'b1;
        wait_ecnt(498); btn[1] = 1'b0;
        wait_ecnt(530);
        chk("glitch_mode", {6'd0, mode}, 8'h00);
        chk("glitch_cnt", led, 8'h0B);

        // Next held 10 ticks: single step to SCAN, then bounce sequence
        btn[1] = 1'b1;
        wait_ecnt(561); chk("next_latency", {6'd0, mode}, 8'h00);
        wait_ecnt(562);
        chk("next_mode", {6'd0, mode}, 8'h01);
        chk("scan_0", led, 8'h01);
        for (int k = 0; k < 8; k++) begin
            wait_ecnt(578 + 16 * k);
            chk($sformatf("scan_%0d", k + 1), led, scan_exp[k]);
        end
        chk("next_once", {6'd0, mode}, 8'h01);
        btn[1] = 1'b0;

        // Async reset mid-SCAN
        wait_ecnt(721); chk("scan_pre_rst", led, 8'h10);
        rst_n = 1'b0;
        #1;
        chk("arst_led", led, 8'h00);
        chk("arst_mode", {6'd0, mode}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        wait_ecnt(17);  chk("rst2_cnt_1", led, 8'h01);

        // Prev from COUNT wraps to MIRROR
        btn[2] = 1'b1;
        wait_ecnt(49);  chk("prev_latency", {6'd0, mode}, 8'h00);
        wait_ecnt(50);
        chk("prev_wrap", {6'd0, mode}, 8'h03);
        chk("mirror_btn2", led, 8'h04);
        btn = 7'b110_0001;
        wait_ecnt(53);  chk("mirror_raw", led, 8'h61);
        btn = 7'd0;

        // Next from MIRROR wraps to COUNT
        wait_ecnt(82);  btn[1] = 1'b1;
        wait_ecnt(113); chk("wrap_latency", {6'd0, mode}, 8'h03);
        wait_ecnt(114);
        chk("next_wrap", {6'd0, mode}, 8'h00);
        chk("wrap_step_clr", led, 8'h00);
        btn[1] = 1'b0;

        // Next and prev accepted together: no change, step keeps running
        wait_ecnt(146); btn[2:1] = 2'b11;
        wait_ecnt(178);
        chk("both_mode", {6'd0, mode}, 8'h00);
        chk("both_cnt_4", led, 8'h04);
        wait_ecnt(194); chk("both_cnt_5", led, 8'h05);
        btn[2:1] = 2'b00;

`ifdef LED_SEQ_PWM_EN
        // Two brightness presses: duty 16 -> 8 -> 4
        wait_ecnt(196); btn[4] = 1'b1;
        wait_ecnt(226); btn[4] = 1'b0;
        wait_ecnt(258); btn[4] = 1'b1;
        wait_ecnt(290); btn[4] = 1'b0;
        wait_ecnt(291);
        on_cnt = 0;
        for (int k = 0; k < 16; k++) begin
            wait_ecnt(292 + k);
            if (led != 8'h00) on_cnt++;
        end
        chk("pwm_duty4", 8'(on_cnt), 8'd4);
`else
        on_cnt = 0;
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/led_sequencer.md
LED_SEQUENCER -- requirements
Module: led_sequencer

Interface
REQ-001 SHALL have parameter TICK_BITS, default 20; prescaler width, one tick per 2^TICK_BITS clocks (~42 ms at 25 MHz).
REQ-002 SHALL have parameter DB_TICKS, default 2; consecutive stable ticks required to accept a button change.
REQ-003 SHALL have port i_clk  input  1  single system clock, all logic on rising edge.
REQ-004 SHALL have port i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port i_btn  input  7  raw asynchronous buttons, active-high: [1] next mode, [2] previous mode, [3] pause toggle, [4] brightness (see Configuration).
REQ-006 SHALL have port o_led  output  8  registered LED drive, active-high.
REQ-007 SHALL have port o_mode  output  2  current mode, registered.

Function
REQ-008 SHALL run a free-running TICK_BITS-bit prescaler; tick is a 1-cycle pulse when the prescaler wraps from all-ones to zero.
REQ-009 SHALL pass every i_btn bit through a 2-flop synchronizer before any use.
REQ-010 SHALL debounce bits [4:1]: per-bit counter increments on tick while synced != accepted, clears when equal; on reaching DB_TICKS, accepted <= synced and counter clears.
REQ-011 SHALL generate a 1-cycle press pulse on each 0->1 transition of an accepted bit; releases produce no pulse.
REQ-012 SHALL implement mode FSM COUNT(0), SCAN(1), BLINK(2), MIRROR(3): next press -> mode+1 mod 4; prev press -> mode-1 mod 4 (0 -> 3, 3 -> 0).
REQ-013 SHALL leave mode unchanged when next and prev press pulses occur in the same cycle.
REQ-014 SHALL clear step counter (8-bit), scan position (3-bit) to 0 and scan direction to up on every mode change.
REQ-015 SHALL toggle paused on each pause press; while paused step and scan position hold; mode changes remain allowed and do not clear paused.
REQ-016 SHALL advance step by 1 (wrapping 255 -> 0) and scan position on each tick when not paused and no mode change occurs that cycle.
REQ-017 SHALL scan positions 0,1,...,7,6,...,1,0,1,...: direction reverses when position reaches 7 or 0 (endpoints shown once per bounce).
REQ-018 SHALL compute pattern: COUNT = step; SCAN = one-hot(position); BLINK = 8'hFF when step[2]=1 else 8'h00; MIRROR = {1'b0, synchronized i_btn[6:0]}.
REQ-019 SHALL register o_led and o_mode with exactly one clock of latency from the internal state/pattern update.

Reset
REQ-020 SHALL, while i_rst_n is low, force asynchronously: o_led=0, o_mode=0, prescaler=0, step=0, position=0, direction up, paused=0, synchronizers, accepted bits and debounce counters=0.
REQ-021 SHALL resume from reset values on the first rising edge after i_rst_n deasserts; no press pulse is generated from reset release.

Configuration
REQ-022 SHALL, with macro LED_SEQ_PWM_EN defined, include a 4-bit free-running PWM counter and duty register (reset 16); btn[4] press cycles duty 16 -> 8 -> 4 -> 1 -> 16; o_led = pattern AND (pwm_cnt < duty).
REQ-023 SHALL, without LED_SEQ_PWM_EN, omit PWM logic and btn[4] debouncing entirely; o_led = pattern at full brightness.

Verification (TICK_BITS=4, DB_TICKS=2)
REQ-024 SHALL cover: i_rst_n low with buttons toggling -> o_led=8'h00, o_mode=0; release -> o_led = 1,2,3 on successive ticks (+1 cycle).
REQ-025 SHALL cover: btn[1] held 10 ticks -> o_mode 0->1 exactly once; o_led 8'h01,8'h02,...,8'h80,8'h40 per tick.
REQ-026 SHALL cover: btn[1] high for 1 tick only -> no mode change; btn[2] press in mode 0 -> o_mode=3.
REQ-027 SHALL cover: btn[1] and btn[2] pressed so accepted in same cycle -> o_mode unchanged.
REQ-028 SHALL cover: COUNT at o_led=8'h05, press btn[3] -> o_led holds 8'h05 for 20 ticks; press again -> 8'h06 next tick.
REQ-029 SHALL cover: i_rst_n pulsed low mid-SCAN (o_led=8'h10) -> o_led=0 and o_mode=0 before next clock edge; with LED_SEQ_PWM_EN, duty 4 -> o_led high 4 of every 16 clocks.
